// File: rtl/spi_master.sv
// Byte-oriented SPI master: shifts one byte MSb-first per handshake in any SPI mode,
// with optional CS_n hold between bytes for multi-byte transactions.
//
// state  | meaning
// IDLE   | CS_n high, ready for a new transaction
// SETUP  | CS_n low, one half-bit before the first SCK edge
// XFER   | issuing 16 SCK edges, one per half-bit
// WAIT   | CS_n held low between bytes, ready for the next byte or a release
// CS_END | SCK idle, CS_n still low for the trailing half-bit
// GAP    | CS_n high, minimum inactive time before the next transaction
module spi_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_Hold,
  input  logic       i_CS_Release,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI,
  output logic       o_SPI_CS_n
);

  localparam logic CPOL = ((SPI_MODE / 2) % 2) == 1;
  localparam logic CPHA = (SPI_MODE % 2) == 1;

  localparam int HW = $clog2(CLKS_PER_HALF_BIT);
  localparam int GW = $clog2(CS_INACTIVE_CLKS + 1);

  localparam logic [HW-1:0] HALF_LOAD = HW'(CLKS_PER_HALF_BIT - 1);
  // CS_END is entered one cycle after the last edge (or the release), so it runs one short
  localparam logic [HW-1:0] END_LOAD  = HW'(CLKS_PER_HALF_BIT - 2);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(CS_INACTIVE_CLKS - 1);
  localparam logic [4:0]    LAST_EDGE = 5'd16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    XFER   = 3'd2,
    WAIT   = 3'd3,
    CS_END = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_half_cnt;
  logic [4:0]    r_edge_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [7:0]    r_tx_shift;
  logic [7:0]    r_rx_shift;
  logic          r_hold;

  logic w_leading;
  logic w_sample;
  logic w_drive;

  // Classify the edge about to be issued: odd edge numbers are leading edges
  assign w_leading = ~r_edge_cnt[0];
  assign w_sample  = w_leading ^ CPHA;
  assign w_drive   = CPHA ? w_leading : (~w_leading && (r_edge_cnt != 5'd15));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state    <= IDLE;
      o_TX_Ready <= 1'b0;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= 8'h00;
      o_SPI_Clk  <= CPOL;
      o_SPI_MOSI <= 1'b0;
      o_SPI_CS_n <= 1'b1;
      r_half_cnt <= '0;
      r_edge_cnt <= '0;
      r_gap_cnt  <= '0;
      r_tx_shift <= 8'h00;
      r_rx_shift <= 8'h00;
      r_hold     <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;

      case (r_state)
        IDLE, WAIT: begin
          o_TX_Ready <= 1'b1;
          if (i_TX_DV && o_TX_Ready) begin
            r_state    <= SETUP;
            o_TX_Ready <= 1'b0;
            o_SPI_CS_n <= 1'b0;
            r_half_cnt <= HALF_LOAD;
            r_edge_cnt <= '0;
            r_hold     <= i_TX_Hold;
            // CPHA=0 must present bit7 before the first edge; CPHA=1 drives it on edge 1
            if (CPHA) begin
              r_tx_shift <= i_TX_Byte;
            end else begin
              o_SPI_MOSI <= i_TX_Byte[7];
              r_tx_shift <= {i_TX_Byte[6:0], 1'b0};
            end
          end else if ((r_state == WAIT) && i_CS_Release) begin
            r_state    <= CS_END;
            o_TX_Ready <= 1'b0;
            r_half_cnt <= END_LOAD;
          end
        end

        SETUP, XFER: begin
          if (r_edge_cnt == LAST_EDGE) begin
            o_RX_DV   <= 1'b1;
            o_RX_Byte <= r_rx_shift;
            if (r_hold) begin
              r_state    <= WAIT;
              o_TX_Ready <= 1'b1;
            end else begin
              r_state    <= CS_END;
              r_half_cnt <= END_LOAD;
            end
          end else if (r_half_cnt == '0) begin
            r_state    <= XFER;
            r_half_cnt <= HALF_LOAD;
            r_edge_cnt <= r_edge_cnt + 5'd1;
            o_SPI_Clk  <= ~o_SPI_Clk;
            if (w_sample) begin
              r_rx_shift <= {r_rx_shift[6:0], i_SPI_MISO};
            end
            if (w_drive) begin
              o_SPI_MOSI <= r_tx_shift[7];
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
          end else begin
            r_half_cnt <= r_half_cnt - HW'(1);
          end
        end

        CS_END: begin
          if (r_half_cnt == '0) begin
            r_state    <= GAP;
            o_SPI_CS_n <= 1'b1;
            r_gap_cnt  <= GAP_LOAD;
          end else begin
            r_half_cnt <= r_half_cnt - HW'(1);
          end
        end

        GAP: begin
          if (r_gap_cnt == '0) begin
            r_state    <= IDLE;
            o_TX_Ready <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end

        default: begin
          r_state    <= IDLE;
          o_SPI_CS_n <= 1'b1;
          o_SPI_Clk  <= CPOL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: four instances cover modes 0..3 with a behavioural
// SPI slave (fixed reply or MISO=MOSI loopback) and bus-rule monitors per instance.
module tb_spi_master;

  logic clk;
  logic rst;

  logic       dv    [4];
  logic [7:0] txb   [4];
  logic       hold  [4];
  logic       rel   [4];
  logic       ready [4];
  logic       rxdv  [4];
  logic [7:0] rxb   [4];
  logic       sck   [4];
  logic       miso  [4];
  logic       mosi  [4];
  logic       csn   [4];
  logic [7:0] reply [4];

  int errors = 0;
  int checks = 0;
  int cur    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: mode 0 H=2, 1: mode 3 H=4, 2: mode 1 H=3 loopback, 3: mode 2 H=3 loopback
  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int   MODE = (i == 0) ? 0 : (i == 1) ? 3 : (i == 2) ? 1 : 2;
    localparam int   HH   = (i == 0) ? 2 : (i == 1) ? 4 : 3;
    localparam logic CPOL = ((MODE / 2) % 2) == 1;
    localparam logic CPHA = (MODE % 2) == 1;

    logic       sl_miso = 1'b0;
    logic       sck_q   = CPOL;
    logic       csn_q   = 1'b1;
    logic [7:0] rx_sh   = 8'h00;
    logic [7:0] rx_last = 8'h00;
    int         bp       = 0;
    int         nbytes   = 0;
    int         rxdv_cnt = 0;
    int         cs_rise  = 0;
    int         viol     = 0;

    spi_master #(
      .SPI_MODE(MODE),
      .CLKS_PER_HALF_BIT(HH),
      .CS_INACTIVE_CLKS(1)
    ) u_dut (
      .i_Clk(clk),
      .i_Rst(rst),
      .i_TX_DV(dv[i]),
      .i_TX_Byte(txb[i]),
      .i_TX_Hold(hold[i]),
      .i_CS_Release(rel[i]),
      .o_TX_Ready(ready[i]),
      .o_RX_DV(rxdv[i]),
      .o_RX_Byte(rxb[i]),
      .o_SPI_Clk(sck[i]),
      .i_SPI_MISO(miso[i]),
      .o_SPI_MOSI(mosi[i]),
      .o_SPI_CS_n(csn[i])
    );

    assign miso[i] = (i >= 2) ? mosi[i] : sl_miso;

    // Slave reacts half a clock after each SCK/CS change; monitors count bus-rule breaks
    always @(negedge clk) begin
      sck_q <= sck[i];
      csn_q <= csn[i];
      if (rxdv[i] === 1'b1) rxdv_cnt <= rxdv_cnt + 1;
      if (csn[i] === 1'b1 && csn_q === 1'b0) cs_rise <= cs_rise + 1;
      if ((sck[i] !== sck_q && csn[i] === 1'b1 && csn_q === 1'b1) ||
          (csn[i] !== csn_q && sck[i] !== CPOL))
        viol <= viol + 1;
      if (csn[i] === 1'b0 && csn_q === 1'b1) begin
        bp    <= 0;
        rx_sh <= 8'h00;
        if (!CPHA) sl_miso <= reply[i][7];
      end else if (csn[i] === 1'b0 && sck[i] !== sck_q) begin
        if ((sck[i] !== CPOL) != CPHA) begin
          rx_sh <= {rx_sh[6:0], mosi[i]};
          if (bp == 7) begin
            rx_last <= {rx_sh[6:0], mosi[i]};
            nbytes  <= nbytes + 1;
            bp      <= 0;
          end else begin
            bp <= bp + 1;
          end
        end else begin
          sl_miso <= reply[i][3'(7 - bp)];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int t);
    while (cur < t) begin
      @(negedge clk);
      cur++;
    end
  endtask

  // Present a byte during cycle T (cur=0); returns in cycle T+1
  task automatic send(input int k, input logic [7:0] b, input logic h);
    dv[k]   = 1'b1;
    txb[k]  = b;
    hold[k] = h;
    cur     = 0;
    @(negedge clk);
    cur   = 1;
    dv[k] = 1'b0;
  endtask

  int n0, r0, c0;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0; txb[k] = 8'h00; hold[k] = 1'b0; rel[k] = 1'b0; reply[k] = 8'h00;
    end

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", ready[0], 0);
    chk("rst_rxdv", rxdv[0], 0);
    chk("rst_rxbyte", rxb[0], 8'h00);
    chk("rst_csn", csn[0], 1);
    chk("rst_mosi", mosi[0], 0);
    chk("rst_sck_m0", sck[0], 0);
    chk("rst_sck_m3", sck[1], 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", ready[0], 1);

    // 1: mode 0, H=2, send A5, slave replies 3C
    repeat (2) @(negedge clk);
    reply[0] = 8'h3C;
    n0 = g_dut[0].nbytes;
    send(0, 8'hA5, 1'b0);
    chk("t1_ready_T1", ready[0], 0);
    chk("t1_csn_T1", csn[0], 0);
    chk("t1_mosi_T1", mosi[0], 1);
    go(2);  chk("t1_sck_T2", sck[0], 0);
    go(3);  chk("t1_sck_T3", sck[0], 1);
    go(33); chk("t1_rxdv_T33", rxdv[0], 0);
            chk("t1_sck_T33", sck[0], 0);
    go(34); chk("t1_rxdv_T34", rxdv[0], 1);
            chk("t1_rxbyte", rxb[0], 8'h3C);
            chk("t1_csn_T34", csn[0], 0);
            chk("t1_ready_T34", ready[0], 0);
    go(35); chk("t1_csn_T35", csn[0], 1);
            chk("t1_rxdv_T35", rxdv[0], 0);
            chk("t1_ready_T35", ready[0], 0);
    go(36); chk("t1_ready_T36", ready[0], 1);
            chk("t1_rxbyte_hold", rxb[0], 8'h3C);
            chk("t1_slave_rx", g_dut[0].rx_last, 8'hA5);
            chk("t1_slave_n", g_dut[0].nbytes, n0 + 1);

    // 2: mode 3, H=4, send 81, slave replies 7E
    reply[1] = 8'h7E;
    chk("t2_sck_idle", sck[1], 1);
    send(1, 8'h81, 1'b0);
    go(4);  chk("t2_sck_T4", sck[1], 1);
    go(5);  chk("t2_sck_T5", sck[1], 0);
    go(9);  chk("t2_sck_T9", sck[1], 1);
    go(65); chk("t2_rxdv_T65", rxdv[1], 0);
    go(66); chk("t2_rxdv_T66", rxdv[1], 1);
            chk("t2_rxbyte", rxb[1], 8'h7E);
            chk("t2_sck_end", sck[1], 1);
    go(68); chk("t2_csn_T68", csn[1], 0);
    go(69); chk("t2_csn_T69", csn[1], 1);
    go(70); chk("t2_ready_T70", ready[1], 1);
            chk("t2_slave_rx", g_dut[1].rx_last, 8'h81);

    // 3: modes 1 and 2, H=3, loopback F0
    chk("t3_idle_m1", sck[2], 0);
    chk("t3_idle_m2", sck[3], 1);
    txb[2] = 8'hF0; txb[3] = 8'hF0; hold[2] = 1'b0; hold[3] = 1'b0;
    dv[2] = 1'b1; dv[3] = 1'b1; cur = 0;
    @(negedge clk);
    cur = 1; dv[2] = 1'b0; dv[3] = 1'b0;
    go(4);  chk("t3_sck_m1_T4", sck[2], 1);
            chk("t3_sck_m2_T4", sck[3], 0);
    go(49); chk("t3_sck_m1_T49", sck[2], 0);
            chk("t3_sck_m2_T49", sck[3], 1);
    go(50); chk("t3_rxdv_m1", rxdv[2], 1);
            chk("t3_rxdv_m2", rxdv[3], 1);
            chk("t3_rxbyte_m1", rxb[2], 8'hF0);
            chk("t3_rxbyte_m2", rxb[3], 8'hF0);
    go(52); chk("t3_csn_m1", csn[2], 1);
    go(53); chk("t3_ready_m2", ready[3], 1);

    // 4: multi-byte, mode 0: 11 (hold), 22 (hold), release
    reply[0] = 8'h3C;
    n0 = g_dut[0].nbytes; r0 = g_dut[0].rxdv_cnt; c0 = g_dut[0].cs_rise;
    send(0, 8'h11, 1'b1);
    go(34); chk("t4_rxdv_b1", rxdv[0], 1);
            chk("t4_ready_b1", ready[0], 1);
            chk("t4_csn_b1", csn[0], 0);
    go(35); chk("t4_csn_wait", csn[0], 0);
            chk("t4_ready_wait", ready[0], 1);
    go(39);
    send(0, 8'h22, 1'b1);
    chk("t4_ready_b2_T1", ready[0], 0);
    chk("t4_csn_b2_T1", csn[0], 0);
    go(34); chk("t4_rxdv_b2", rxdv[0], 1);
            chk("t4_rxbyte_b2", rxb[0], 8'h3C);
            chk("t4_ready_b2", ready[0], 1);
    go(36); rel[0] = 1'b1;
    go(37); rel[0] = 1'b0;
            chk("t4_ready_rel1", ready[0], 0);
            chk("t4_csn_rel1", csn[0], 0);
            chk("t4_no_rise", g_dut[0].cs_rise, c0);
    go(38); chk("t4_csn_rel2", csn[0], 1);
    go(39); chk("t4_ready_rel3", ready[0], 1);
            chk("t4_rxdv_cnt", g_dut[0].rxdv_cnt, r0 + 2);
            chk("t4_slave_rx", g_dut[0].rx_last, 8'h22);
            chk("t4_slave_n", g_dut[0].nbytes, n0 + 2);

    // 5a: DV while busy is dropped
    reply[0] = 8'hC3;
    n0 = g_dut[0].nbytes; r0 = g_dut[0].rxdv_cnt;
    send(0, 8'h33, 1'b0);
    go(10); dv[0] = 1'b1; txb[0] = 8'h44;
    go(11); dv[0] = 1'b0;
            chk("t5_ready_busy", ready[0], 0);
    go(34); chk("t5_rxdv", rxdv[0], 1);
            chk("t5_rxbyte", rxb[0], 8'hC3);
    go(70); chk("t5_rxdv_cnt", g_dut[0].rxdv_cnt, r0 + 1);
            chk("t5_slave_n", g_dut[0].nbytes, n0 + 1);
            chk("t5_slave_rx", g_dut[0].rx_last, 8'h33);
            chk("t5_csn_idle", csn[0], 1);

    // 5b: DV and release together in WAIT: byte sent, CS_n kept low
    send(0, 8'h55, 1'b1);
    go(34); chk("t5b_wait_ready", ready[0], 1);
    go(36); dv[0] = 1'b1; txb[0] = 8'h66; hold[0] = 1'b1; rel[0] = 1'b1;
    go(37); dv[0] = 1'b0; rel[0] = 1'b0;
            chk("t5b_ready", ready[0], 0);
            chk("t5b_csn", csn[0], 0);
    go(70); chk("t5b_rxdv", rxdv[0], 1);
            chk("t5b_csn_done", csn[0], 0);
            chk("t5b_ready_done", ready[0], 1);
    go(71); chk("t5b_csn_wait", csn[0], 0);
            rel[0] = 1'b1;
    go(72); rel[0] = 1'b0;
    go(73); chk("t5b_csn_rise", csn[0], 1);
    go(74); chk("t5b_ready_end", ready[0], 1);
            chk("t5b_slave_rx", g_dut[0].rx_last, 8'h66);

    // 6: reset at edge 7, then a clean transfer
    r0 = g_dut[0].rxdv_cnt;
    send(0, 8'h99, 1'b0);
    go(15); chk("t6_sck_e7", sck[0], 1);
            rst = 1'b1;
    go(16); rst = 1'b0;
            chk("t6_csn", csn[0], 1);
            chk("t6_sck", sck[0], 0);
            chk("t6_ready", ready[0], 0);
            chk("t6_rxdv", rxdv[0], 0);
    go(17); chk("t6_ready_after", ready[0], 1);
    go(60); chk("t6_no_rxdv", g_dut[0].rxdv_cnt, r0);
    reply[0] = 8'h96;
    send(0, 8'h5A, 1'b0);
    go(34); chk("t6_rxdv_new", rxdv[0], 1);
            chk("t6_rxbyte_new", rxb[0], 8'h96);
    go(36); chk("t6_ready_new", ready[0], 1);
            chk("t6_slave_rx", g_dut[0].rx_last, 8'h5A);

    chk("viol_m0", g_dut[0].viol, 0);
    chk("viol_m3", g_dut[1].viol, 0);
    chk("viol_m1", g_dut[2].viol, 0);
    chk("viol_m2", g_dut[3].viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
